// File: rtl/dlx_mem_responder.sv
// Memory-side responder for the DLX core port: word-addressed RAM behind a
// fixed number of wait states, returning a one-cycle ACK with data or a fault.
module dlx_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] MMU_AO,
    input  logic [31:0] DO,
    input  logic        MR,
    input  logic        MW,
    output logic [31:0] DI,
    output logic        ACK,
    output logic        BUSY,
    output logic        FAULT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          wait_cnt;
    logic [ADDR_W-1:0]   idx_lat;
    logic [31:0]         data_lat;
    logic                rd_lat;
    logic                wr_lat;

    logic [31:0]         ram [2**ADDR_W];

    logic                accept;
    logic                req_fault;
    logic [ADDR_W-1:0]   cur_idx;
    logic [31:0]         cur_data;
    logic                cur_rd;
    logic                cur_wr;

    logic                good_done;
    logic                ram_we;
    logic                ack_nxt;
    logic                busy_nxt;
    logic                fault_nxt;
    logic [31:0]         di_nxt;

    // With zero wait states the access completes on the accepting edge, so the
    // live inputs stand in for the latched request while in IDLE.
    always_comb begin
        accept    = (state == S_IDLE) && (MR || MW);
        req_fault = accept &&
                    ((MMU_AO[31:24] != 8'd0) ||
                     ((MMU_AO[23:0] >> (ADDR_W + 2)) != 24'd0) ||
                     (MMU_AO[1:0] != 2'd0) ||
                     (MR && MW));
        if (state == S_IDLE) begin
            cur_idx  = MMU_AO[ADDR_W+1:2];
            cur_data = DO;
            cur_rd   = MR;
            cur_wr   = MW;
        end else begin
            cur_idx  = idx_lat;
            cur_data = data_lat;
            cur_rd   = rd_lat;
            cur_wr   = wr_lat;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if ((WAIT_CYCLES > 0) && !req_fault) begin
                        state_nxt = S_WAIT;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; they take effect on the edge
    // that enters the corresponding state.
    always_comb begin
        good_done = (state_nxt == S_DONE) && !req_fault;
        ram_we    = good_done && cur_wr;
        ack_nxt   = (state_nxt == S_DONE);
        busy_nxt  = (state_nxt == S_WAIT);
        fault_nxt = (state_nxt == S_DONE) && req_fault;
        di_nxt    = 32'd0;
        if (good_done && cur_rd) begin
            di_nxt = ram[cur_idx];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            rd_lat   <= 1'b0;
            wr_lat   <= 1'b0;
            ACK      <= 1'b0;
            BUSY     <= 1'b0;
            FAULT    <= 1'b0;
            DI       <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wait_cnt <= WAIT_LOAD;
                rd_lat   <= MR;
                wr_lat   <= MW;
            end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            ACK   <= ack_nxt;
            BUSY  <= busy_nxt;
            FAULT <= fault_nxt;
            DI    <= di_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            idx_lat  <= MMU_AO[ADDR_W+1:2];
            data_lat <= DO;
        end
    end

    // A write coinciding with RESET is dropped along with the transaction.
    always_ff @(posedge CLK) begin
        if (ram_we && !RESET) begin
            ram[cur_idx] <= cur_data;
        end
    end

endmodule

// File: tb/tb_dlx_mem_responder.sv
// Bench for dlx_mem_responder: a WAIT_CYCLES=2 unit and a WAIT_CYCLES=0 unit
// driven by per-scenario tasks and checked against an array-based memory model.
module tb_dlx_mem_responder;

    localparam int RAM_BYTES = 4 * 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ao   [2];
    logic [31:0] dout [2];
    logic [31:0] di   [2];
    logic        mr   [2];
    logic        mw   [2];
    logic        ack  [2];
    logic        busy [2];
    logic        fault[2];

    logic [31:0] mem [2][1024];
    int          errors = 0;
    int          checks = 0;
    string       cur_test = "none";

    always #5 clk = ~clk;

    dlx_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_w2 (
        .CLK(clk), .RESET(rst), .MMU_AO(ao[0]), .DO(dout[0]), .MR(mr[0]), .MW(mw[0]),
        .DI(di[0]), .ACK(ack[0]), .BUSY(busy[0]), .FAULT(fault[0])
    );

    dlx_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_w0 (
        .CLK(clk), .RESET(rst), .MMU_AO(ao[1]), .DO(dout[1]), .MR(mr[1]), .MW(mw[1]),
        .DI(di[1]), .ACK(ack[1]), .BUSY(busy[1]), .FAULT(fault[1])
    );

    function automatic bit is_fault(input logic rd, input logic wr, input logic [31:0] a);
        return (a >= RAM_BYTES) || (a % 4 != 0) || (rd && wr);
    endfunction

    // One complete transaction on unit u; checks every cycle up to the ACK.
    task automatic txn(input int u, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input bit chg);
        int          lat;
        bit          f;
        logic [31:0] exp_di;
        f      = is_fault(rd, wr, a);
        lat    = f ? 1 : ((u == 0) ? 3 : 1);
        exp_di = 32'd0;
        if (!f && rd) exp_di = mem[u][a >> 2];
        @(negedge clk);
        checks++;
        if (ack[u] !== 1'b0 || busy[u] !== 1'b0) begin
            errors++;
            $display("FAIL %s/idle_before u%0d: got ack=%b busy=%b want 0 0", cur_test, u, ack[u], busy[u]);
        end
        ao[u] = a; dout[u] = d; mr[u] = rd; mw[u] = wr;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (chg && k == 1) begin
                ao[u] = 32'h0000_0020; dout[u] = 32'h1234_5678;
            end
            checks++;
            if (ack[u] !== (k == lat)) begin
                errors++;
                $display("FAIL %s/ack u%0d a=%h k=%0d: got %b want %b", cur_test, u, a, k, ack[u], (k == lat));
            end
            checks++;
            if (busy[u] !== (k < lat)) begin
                errors++;
                $display("FAIL %s/busy u%0d a=%h k=%0d: got %b want %b", cur_test, u, a, k, busy[u], (k < lat));
            end
            checks++;
            if (fault[u] !== ((k == lat) && f)) begin
                errors++;
                $display("FAIL %s/fault u%0d a=%h k=%0d: got %b want %b", cur_test, u, a, k, fault[u], ((k == lat) && f));
            end
            if (k == lat) begin
                checks++;
                if (di[u] !== exp_di) begin
                    errors++;
                    $display("FAIL %s/di u%0d a=%h: got %h want %h", cur_test, u, a, di[u], exp_di);
                end
            end
        end
        if (!f && wr) mem[u][a >> 2] = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                mr[u] = 1'b0; mw[u] = 1'b0;
                checks++;
                if (ack[u] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s/idle_ack u%0d: got %b want 0", cur_test, u, ack[u]);
                end
            end
        end
    endtask

    task automatic test_reset();
        cur_test = "reset";
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            ao[u] = 32'd0; dout[u] = 32'd0; mr[u] = 1'b0; mw[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({ack[u], busy[u], fault[u], di[u]} !== 35'd0) begin
                errors++;
                $display("FAIL reset/outputs u%0d: got ack=%b busy=%b fault=%b di=%h want all 0",
                         u, ack[u], busy[u], fault[u], di[u]);
            end
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_write_read();
        cur_test = "write_read";
        for (int u = 0; u < 2; u++) begin
            txn(u, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
            txn(u, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
            idle(1);
        end
    endtask

    task automatic test_faults();
        cur_test = "faults";
        for (int u = 0; u < 2; u++) begin
            txn(u, 1'b1, 1'b0, 32'h0100_0000, 32'h0, 1'b0);
            txn(u, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0);
            txn(u, 1'b1, 1'b0, 32'h0000_0012, 32'h0, 1'b0);
            txn(u, 1'b1, 1'b1, 32'h0000_0010, 32'h0, 1'b0);
            txn(u, 1'b0, 1'b1, 32'h0100_0010, 32'hCAFE_F00D, 1'b0);
            txn(u, 1'b0, 1'b1, 32'h0000_0FFE, 32'hCAFE_F00D, 1'b0);
            txn(u, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
            idle(1);
        end
    endtask

    task automatic test_wait0_stream();
        cur_test = "wait0_stream";
        txn(1, 1'b0, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 1'b0);
        idle(1);
        @(negedge clk);
        ao[1] = 32'h0000_0040; mr[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (ack[1] !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL wait0_stream/ack k=%0d: got %b want %b", k, ack[1], (k % 2 == 1));
            end
            checks++;
            if (busy[1] !== 1'b0) begin
                errors++;
                $display("FAIL wait0_stream/busy k=%0d: got %b want 0", k, busy[1]);
            end
            if (k % 2 == 1) begin
                checks++;
                if (di[1] !== mem[1][16]) begin
                    errors++;
                    $display("FAIL wait0_stream/di k=%0d: got %h want %h", k, di[1], mem[1][16]);
                end
            end
        end
        mr[1] = 1'b0;
        idle(2);
    endtask

    task automatic test_input_stability();
        cur_test = "input_stability";
        txn(0, 1'b0, 1'b1, 32'h0000_0020, 32'h2020_2020, 1'b0);
        txn(0, 1'b0, 1'b1, 32'h0000_0010, 32'h55AA_55AA, 1'b1);
        txn(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        txn(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
        txn(0, 1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b1);
        txn(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        txn(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
        idle(1);
    endtask

    task automatic test_reset_mid_write();
        cur_test = "reset_mid_write";
        txn(0, 1'b0, 1'b1, 32'h0000_0030, 32'h1111_1111, 1'b0);
        idle(1);
        @(negedge clk);
        ao[0] = 32'h0000_0030; dout[0] = 32'hA5A5_A5A5; mw[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_write/busy_before: got %b want 1", busy[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ack[0], busy[0], fault[0], di[0]} !== 35'd0) begin
            errors++;
            $display("FAIL reset_mid_write/outputs: got ack=%b busy=%b fault=%b di=%h want all 0",
                     ack[0], busy[0], fault[0], di[0]);
        end
        rst = 1'b0; mw[0] = 1'b0;
        idle(4);
        txn(0, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 1'b0);
        idle(1);
    endtask

    task automatic test_back_to_back();
        cur_test = "back_to_back";
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 4; i++) begin
                txn(u, 1'b0, 1'b1, 32'h0000_0004, $urandom, 1'b0);
                txn(u, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b0);
                txn(u, 1'b0, 1'b1, 32'h0000_0008, $urandom, 1'b0);
                txn(u, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b0);
            end
            idle(1);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        rd;
        logic        wr;
        int          r;
        cur_test = "random";
        for (int u = 0; u < 2; u++) begin
            for (int w = 0; w < 16; w++) txn(u, 1'b0, 1'b1, 32'(w * 4), $urandom, 1'b0);
            for (int i = 0; i < 60; i++) begin
                r = $urandom_range(0, 9);
                case (r)
                    0: a = $urandom | 32'h0100_0000;
                    1: a = 32'h0000_1000 + 32'($urandom_range(0, 255) * 4);
                    2: a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                    default: a = 32'($urandom_range(0, 15) * 4);
                endcase
                r = $urandom_range(0, 7);
                rd = (r == 0) || (r >= 4);
                wr = (r < 4);
                txn(u, rd, wr, a, $urandom, 1'b0);
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            end
            idle(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_faults();
        test_wait0_stream();
        test_input_stability();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dlx_mem_responder.md
Name: dlx_mem_responder

Overview:
Memory-side responder for the DLX data/instruction port. Consumes the translated 32-bit address produced by the address-translation stage, plus the read/write strobes and store data from the core. Services each request from an internal word-addressed RAM after a programmable number of wait states. Returns a one-cycle acknowledge with read data, or an access fault.

Parameters:
ADDR_W, 10, word-index width; RAM holds 2**ADDR_W 32-bit words (4 KB default)
WAIT_CYCLES, 2, wait states inserted between request acceptance and ACK (0..15 legal)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
MMU_AO  input  32  translated byte address; only [23:0] is a legal physical address
DO  input  32  store data from core
MR  input  1  read request, held until ACK
MW  input  1  write request, held until ACK
DI  output  32  read data, valid only while ACK=1
ACK  output  1  one-cycle transaction-complete pulse
BUSY  output  1  high while a transaction is accepted but not yet acknowledged
FAULT  output  1  qualifies ACK; 1 = access rejected

Behaviour:
- One clock, CLK. RESET is synchronous and active-high. All outputs are registered.
- Reset values: DI=0, ACK=0, BUSY=0, FAULT=0, state=IDLE, wait counter=0. RAM contents are not cleared by reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE: in cycle T, if MR|MW is sampled high, the request is accepted.
  - Latch MMU_AO, DO and the request type.
  - Evaluate the fault condition.
  - Next state: WAIT if WAIT_CYCLES>0 and no fault; otherwise DONE.
  - BUSY rises at T+1.
- WAIT: the counter loads WAIT_CYCLES-1 on entry and decrements each cycle. At 0, next state is DONE.
- DONE, entered at cycle T+WAIT_CYCLES+1 on a good access:
  - ACK=1, BUSY=0.
  - Read: DI = RAM[idx].
  - Write: RAM[idx] <= latched DO on the edge entering DONE; DI=0.
  - Next state is always IDLE; ACK drops the following cycle.
- Latency: ACK at T+WAIT_CYCLES+1 for good accesses; ACK at T+1 for faulted accesses.
- Word index: idx = latched addr[ADDR_W+1:2].
- Fault condition, evaluated at acceptance, any of:
  - addr[31:24] != 0;
  - addr[23:ADDR_W+2] != 0 (beyond RAM);
  - addr[1:0] != 0 (misaligned word access);
  - MR & MW both high.
- Fault response: skip WAIT, DONE at T+1 with ACK=1, FAULT=1, DI=0; no RAM write.
- FAULT is 0 whenever ACK is 0.
- Request inputs are ignored in WAIT and DONE. Changes to MMU_AO/DO/MR/MW after acceptance have no effect.
- Back-to-back: the core drops or changes the request on the edge after seeing ACK. IDLE samples the new request in the cycle after DONE, so back-to-back transactions are separated by exactly one IDLE cycle.
- RESET in WAIT or DONE: return to IDLE with all outputs at reset values. A pending write (still in WAIT) is discarded; a write on the same edge as RESET is not performed.
- RESET has priority over request acceptance in the same cycle.
- Read of a never-written word returns X in simulation. The bench initialises RAM via writes.

Test Plan:
- Write then read, WAIT_CYCLES=2: MW=1, MMU_AO=0x00000010, DO=0xDEADBEEF at T=5 -> ACK=1 only at T=8, BUSY=1 at T=6..7. Then MR=1, same address, at T=9 -> ACK at T=12 with DI=0xDEADBEEF, FAULT=0.
- Faults: MMU_AO=0x01000000 read -> ACK+FAULT at T+1, DI=0. MMU_AO=0x00001000 (ADDR_W=10) -> FAULT. MMU_AO=0x00000012 -> FAULT. MR=MW=1 -> FAULT. A faulting write to 0x01000010 leaves word 0x10 reading 0xDEADBEEF.
- WAIT_CYCLES=0 build: read at T -> ACK at T+1, BUSY never asserted. Continuous MR held for 10 cycles -> ACK every 2nd cycle.
- Input stability: change MMU_AO to 0x00000020 and DO to 0x12345678 one cycle after a write to 0x10 is accepted -> 0x10 holds 0x12345678 only if DO was 0x12345678 at acceptance; 0x20 is unchanged.
- Reset mid-write: MW to 0x00000030, DO=0xA5A5A5A5; assert RESET at T+1 (in WAIT) -> outputs 0 at T+2, no ACK. A later read of 0x30 returns the prior value (written 0x11111111 beforehand).
- Back-to-back: alternating write/read of 0x04 and 0x08 issued immediately after each ACK -> exactly one IDLE cycle between DONE and the next BUSY, data round-trips correctly.
